hazard_scoreboard: RTL and testbench

//   Parametrised hazard/forwarding unit for the decode stage of the pipeline.

---
 rtl/hazard_scoreboard.sv | 77 +++++++
 tb/tb_hazard_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard/forwarding unit: tracks in-flight destinations in a DEPTH-entry
// shift register and derives Stall, per-operand forward selects and a stall counter.
module hazard_scoreboard #(
    parameter  int DEPTH      = 3,
    parameter  int AW         = 5,
    parameter  int LOAD_READY = 2,
    parameter  int CW         = 16,
    localparam int FW         = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          IssueValid,
    input  logic [AW-1:0] Rs,
    input  logic [AW-1:0] Rt,
    input  logic          UsesRs,
    input  logic          UsesRt,
    input  logic [AW-1:0] Rd,
    input  logic          RegWrite,
    input  logic          IsLoad,
    input  logic          Flush,
    output logic          Stall,
    output logic [FW-1:0] FwdA,
    output logic [FW-1:0] FwdB,
    output logic [CW-1:0] StallCount
);

    logic          ent_v  [1:DEPTH];
    logic [AW-1:0] ent_rd [1:DEPTH];
    logic          ent_ld [1:DEPTH];

    logic rdy_a, rdy_b, accept;

    // Scan oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        FwdA  = '0;
        FwdB  = '0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        for (int k = DEPTH; k >= 1; k--) begin
            if (UsesRs && Rs != '0 && ent_v[k] && ent_rd[k] == Rs) begin
                FwdA  = FW'(k);
                rdy_a = !ent_ld[k] || (k >= LOAD_READY);
            end
            if (UsesRt && Rt != '0 && ent_v[k] && ent_rd[k] == Rt) begin
                FwdB  = FW'(k);
                rdy_b = !ent_ld[k] || (k >= LOAD_READY);
            end
        end
    end

    assign Stall  = IssueValid && !Flush && (!rdy_a || !rdy_b);
    assign accept = IssueValid && !Stall && !Flush;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                ent_v[k]  <= 1'b0;
                ent_rd[k] <= '0;
                ent_ld[k] <= 1'b0;
            end
            StallCount <= '0;
        end else begin
            for (int k = 2; k <= DEPTH; k++) begin
                ent_v[k]  <= ent_v[k-1];
                ent_rd[k] <= ent_rd[k-1];
                ent_ld[k] <= ent_ld[k-1];
            end
            // Stalled, flushed or idle cycles push a bubble into stage 1.
            ent_v[1]  <= accept && RegWrite && (Rd != '0);
            ent_rd[1] <= Rd;
            ent_ld[1] <= IsLoad;
            if (Stall && StallCount != '1)
                StallCount <= StallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: default instance plus a DEPTH=5/LOAD_READY=3/CW=2 instance,
// directed scenarios then random traffic, checked against an age-based reference model.
module tb_hazard_scoreboard;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       IssueValid = 1'b0;
    logic [4:0] Rs = '0, Rt = '0, Rd = '0;
    logic       UsesRs = 1'b0, UsesRt = 1'b0, RegWrite = 1'b0, IsLoad = 1'b0, Flush = 1'b0;

    logic        s0, s1;
    logic [1:0]  fa0, fb0;
    logic [2:0]  fa1, fb1;
    logic [15:0] c0;
    logic [1:0]  c1;

    always #5 Clk = ~Clk;

    hazard_scoreboard dut0 (
        .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .Rs(Rs), .Rt(Rt),
        .UsesRs(UsesRs), .UsesRt(UsesRt), .Rd(Rd), .RegWrite(RegWrite), .IsLoad(IsLoad),
        .Flush(Flush), .Stall(s0), .FwdA(fa0), .FwdB(fb0), .StallCount(c0)
    );

    hazard_scoreboard #(.DEPTH(5), .AW(5), .LOAD_READY(3), .CW(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .Rs(Rs), .Rt(Rt),
        .UsesRs(UsesRs), .UsesRt(UsesRt), .Rd(Rd), .RegWrite(RegWrite), .IsLoad(IsLoad),
        .Flush(Flush), .Stall(s1), .FwdA(fa1), .FwdB(fb1), .StallCount(c1)
    );

    // Model: every accepted writer is remembered with the step it issued on; its pipeline
    // stage is simply its age in steps.
    typedef struct { int d; int cyc; int rd; bit ld; } rec_t;
    typedef struct { int d; bit st; int fa; int fb; int cnt; } exp_t;

    rec_t hist[$];
    exp_t exp_q[$];
    int   cnt[2] = '{0, 0};
    int   now = 0;
    int   n_cmp = 0, n_bad = 0;

    task automatic cmp(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic void find(input int d, input int depth, input int lr, input bit u,
                                 input int r, output int fwd, output bit nr);
        fwd = 0;
        nr  = 0;
        if (!u || r == 0) return;
        foreach (hist[i]) begin
            int age;
            age = now - hist[i].cyc;
            if (hist[i].d == d && hist[i].rd == r && age >= 1 && age <= depth &&
                (fwd == 0 || age < fwd)) begin
                fwd = age;
                nr  = hist[i].ld && (age < lr);
            end
        end
    endfunction

    task automatic step(input bit rst, input bit iv, input int rs, input int rt,
                        input bit urs, input bit urt, input int rd, input bit rw,
                        input bit ld, input bit fl);
        @(posedge Clk);
        #1;
        Reset = rst; IssueValid = iv; Rs = 5'(rs); Rt = 5'(rt); UsesRs = urs; UsesRt = urt;
        Rd = 5'(rd); RegWrite = rw; IsLoad = ld; Flush = fl;
        now++;
        if (rst) begin
            hist.delete();
            cnt = '{0, 0};
            for (int d = 0; d < 2; d++) exp_q.push_back('{d, 1'b0, 0, 0, 0});
        end else begin
            for (int d = 0; d < 2; d++) begin
                int depth, lr, maxc, fa, fb;
                bit na, nb, st;
                depth = (d == 0) ? 3 : 5;
                lr    = (d == 0) ? 2 : 3;
                maxc  = (d == 0) ? 65535 : 3;
                find(d, depth, lr, urs, rs, fa, na);
                find(d, depth, lr, urt, rt, fb, nb);
                st = iv && !fl && (na || nb);
                exp_q.push_back('{d, st, fa, fb, cnt[d]});
                if (iv && !st && !fl && rw && rd != 0) hist.push_back('{d, now, rd, ld});
                if (st && cnt[d] < maxc) cnt[d]++;
            end
            while (hist.size() > 0 && now - hist[0].cyc > 8) void'(hist.pop_front());
        end
    endtask

    task automatic bubble(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reader(input int rs, input int rt);
        step(0, 1, rs, rt, 1, 1, 0, 0, 0, 0);
    endtask

    always @(negedge Clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.d == 0) begin
                cmp("stall0", int'(s0), int'(e.st));
                cmp("fwda0", int'(fa0), e.fa);
                cmp("fwdb0", int'(fb0), e.fb);
                cmp("count0", int'(c0), e.cnt);
            end else begin
                cmp("stall1", int'(s1), int'(e.st));
                cmp("fwda1", int'(fa1), e.fa);
                cmp("fwdb1", int'(fb1), e.fb);
                cmp("count1", int'(c1), e.cnt);
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ALU chain: add r3, then add r4,r3,r3, then readers of r3
        step(0, 1, 1, 2, 1, 1, 3, 1, 0, 0);
        step(0, 1, 3, 3, 1, 1, 4, 1, 0, 0);
        #2 cmp("alu_fa1", int'(fa0), 1); cmp("alu_fb1", int'(fb0), 1); cmp("alu_st", int'(s0), 0);
        reader(3, 0);
        #2 cmp("alu_fa2", int'(fa0), 2);
        reader(3, 0);
        #2 cmp("alu_fa3", int'(fa0), 3); cmp("alu_fa3_d5", int'(fa1), 3);
        bubble(6);

        // Load-use
        step(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
        reader(5, 0);
        #2 cmp("lu_st_c1", int'(s0), 1); cmp("lu_st_c1_d5", int'(s1), 1);
        reader(5, 0);
        #2 cmp("lu_st_c2", int'(s0), 0); cmp("lu_fa_c2", int'(fa0), 2);
        cmp("lu_st_c2_d5", int'(s1), 1);
        reader(5, 0);
        #2 cmp("lu_st_c3_d5", int'(s1), 0); cmp("lu_fa_c3_d5", int'(fa1), 3);
        cmp("lu_cnt", int'(c0), 1); cmp("lu_cnt_d5", int'(c1), 2);
        bubble(6);

        // Shadowing: lw r6, add r6, reader r6
        step(0, 1, 0, 0, 0, 0, 6, 1, 1, 0);
        step(0, 1, 1, 1, 0, 0, 6, 1, 0, 0);
        reader(6, 0);
        #2 cmp("shadow_fa", int'(fa0), 1); cmp("shadow_st", int'(s0), 0);
        cmp("shadow_st_d5", int'(s1), 0);
        bubble(6);

        // r0 writes and flushed load
        step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        reader(0, 0);
        #2 cmp("zero_fa", int'(fa0), 0); cmp("zero_st", int'(s0), 0);
        step(0, 1, 0, 0, 0, 0, 7, 1, 1, 1);
        reader(7, 7);
        #2 cmp("flush_st", int'(s0), 0); cmp("flush_fa", int'(fa0), 0);
        cmp("flush_st_d5", int'(s1), 0);
        bubble(6);

        // Second load-use drives the CW=2 counter into saturation
        step(0, 1, 0, 0, 0, 0, 9, 1, 1, 0);
        reader(0, 9);
        reader(0, 9);
        reader(0, 9);
        #2 cmp("sat_cnt_d5", int'(c1), 3); cmp("sat_cnt", int'(c0), 2);
        cmp("sat_fb_d5", int'(fb1), 3);
        bubble(6);

        // Async reset with three live entries and a pending load-use hazard
        step(0, 1, 0, 0, 0, 0, 8, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 9, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 10, 1, 1, 0);
        step(1, 1, 10, 9, 1, 1, 0, 0, 0, 0);
        #2 cmp("rst_st", int'(s0), 0); cmp("rst_fa", int'(fa0), 0); cmp("rst_fb", int'(fb0), 0);
        cmp("rst_cnt", int'(c0), 0); cmp("rst_cnt_d5", int'(c1), 0);
        reader(10, 9);
        #2 cmp("post_rst_fa", int'(fa0), 0); cmp("post_rst_st", int'(s0), 0);

        // Random traffic on a small register window
        for (int i = 0; i < 500; i++) begin
            bit rst;
            rst = ($urandom_range(0, 99) == 0);
            step(rst, $urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
        end

        @(negedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
